uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a send/busy handshake.
// Keeps at most one byte outstanding and holds it stable until the next pop.
module uart_tx_fifo #(
    parameter int unsigned DATA_UART  = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic [DATA_UART-1:0]  wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic [DATA_UART-1:0]  tx_data_o,
    output logic                  tx_send_o,
    input  logic                  tx_busy_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   empty_q, empty_d;
    logic                   full_q, full_d;
    logic                   overflow_q, overflow_d;
    logic                   tx_send_q, tx_send_d;
    logic [DATA_UART-1:0]   tx_data_q, tx_data_d;
    logic                   push;
    logic                   pop;

    logic [DATA_UART-1:0]   mem_q [DEPTH];

    // Storage is not reset; occupancy is tracked entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_send_q  <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            tx_send_q  <= tx_send_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_send_d  = tx_send_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        push       = wr_valid_i && !full_q && !flush_i;

        // Flush blocks a new pop but never disturbs a handshake already underway.
        case (state_q)
            ST_IDLE: begin
                if (en_i && !empty_q && !tx_busy_i && !flush_i) begin
                    pop       = 1'b1;
                    state_d   = ST_SEND;
                    tx_send_d = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                end
            end
            ST_SEND: begin
                if (tx_busy_i) begin
                    state_d   = ST_WAIT_DONE;
                    tx_send_d = 1'b0;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tx_send_d = 1'b0;
            end
        endcase

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (wr_valid_i && full_q) begin
                overflow_d = 1'b1;
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    assign wr_ready_o = !full_q;
    assign tx_data_o  = tx_data_q;
    assign tx_send_o  = tx_send_q;
    assign count_o    = count_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed vector table plus hand-written sequences for uart_tx_fifo,
// with a simple transmitter model answering the send/busy handshake.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] wd = 8'h00;
    logic       wv = 1'b0;
    logic       busy = 1'b0;
    logic       ready;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_UART(8), .DEPTH_LOG2(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .flush_i    (flush),
        .wr_data_i  (wd),
        .wr_valid_i (wv),
        .wr_ready_o (ready),
        .tx_data_o  (tx_data),
        .tx_send_o  (tx_send),
        .tx_busy_i  (busy),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full),
        .overflow_o (ovf)
    );

    typedef struct {
        logic       rst, en, flush, wv;
        logic [7:0] wd;
        logic       busy;
        logic       send;
        logic [7:0] data;
        logic [4:0] cnt;
        logic       emp, ful, ov, rdy;
    } vec_t;

    vec_t       tbl [23];
    logic [7:0] q [$];

    function automatic vec_t mk(input logic r, e, f, v, input logic [7:0] d, input logic b,
                                input logic s, input logic [7:0] xd, input logic [4:0] c,
                                input logic em, fu, ov_, rd);
        vec_t t;
        t.rst = r; t.en = e; t.flush = f; t.wv = v; t.wd = d; t.busy = b;
        t.send = s; t.data = xd; t.cnt = c; t.emp = em; t.ful = fu; t.ov = ov_; t.rdy = rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic s, input logic [7:0] d, input logic [4:0] c,
                           input logic em, fu, ov_, rd);
        chk({tag, ".send"},  tx_send, s);
        chk({tag, ".data"},  tx_data, d);
        chk({tag, ".count"}, count,   c);
        chk({tag, ".empty"}, empty,   em);
        chk({tag, ".full"},  full,    fu);
        chk({tag, ".ovf"},   ovf,     ov_);
        chk({tag, ".ready"}, ready,   rd);
    endtask

    // Transmitter model: wait for a send, go busy for busy_cycles, then release.
    task automatic send_one(input logic [7:0] exp, input int busy_cycles);
        int   t;
        logic bad;
        t = 0;
        while (tx_send !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk($sformatf("send_seen[%0h]", exp), tx_send, 1);
        chk($sformatf("send_data[%0h]", exp), tx_data, exp);
        busy = 1'b1;
        step();
        chk($sformatf("send_drop[%0h]", exp), tx_send, 0);
        bad = 1'b0;
        for (int k = 1; k < busy_cycles; k++) begin
            step();
            if (tx_data !== exp || tx_send !== 1'b0) bad = 1'b1;
        end
        chk($sformatf("busy_stable[%0h]", exp), bad, 0);
        busy = 1'b0;
        step();
    endtask

    task automatic push(input logic [7:0] d);
        wv = 1'b1;
        wd = d;
        step();
        wv = 1'b0;
    endtask

    initial begin
        int sends;

        //             rst en fl wv wd     bsy  send data   cnt emp ful ovf rdy
        tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0,   0, 8'h00, 0, 1, 0, 0, 1);
        tbl[1]  = mk(0, 1, 0, 1, 8'h55, 0,   0, 8'h00, 1, 0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 0, 0, 8'h00, 0,   1, 8'h55, 0, 1, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, 0, 8'h00, 1,   0, 8'h55, 0, 1, 0, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0, 8'h00, 1,   0, 8'h55, 0, 1, 0, 0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 8'h00, 0,   0, 8'h55, 0, 1, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 1, 8'h3C, 0,   0, 8'h55, 1, 0, 0, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 8'h00, 0,   1, 8'h3C, 0, 1, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 8'h00, 0,   1, 8'h3C, 0, 1, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 8'h00, 1,   0, 8'h3C, 0, 1, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 8'h00, 0,   0, 8'h3C, 0, 1, 0, 0, 1);
        tbl[11] = mk(0, 0, 1, 1, 8'h77, 0,   0, 8'h3C, 0, 1, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 1, 8'h11, 0,   0, 8'h3C, 1, 0, 0, 0, 1);
        tbl[13] = mk(0, 1, 1, 1, 8'h22, 0,   0, 8'h3C, 0, 1, 0, 0, 1);
        tbl[14] = mk(0, 1, 0, 0, 8'h00, 0,   0, 8'h3C, 0, 1, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 1, 8'h44, 0,   0, 8'h3C, 1, 0, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 1, 8'h45, 0,   1, 8'h44, 1, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 8'h00, 1,   0, 8'h44, 1, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 8'h00, 0,   0, 8'h44, 1, 0, 0, 0, 1);
        tbl[19] = mk(0, 1, 0, 0, 8'h00, 0,   1, 8'h45, 0, 1, 0, 0, 1);
        tbl[20] = mk(0, 1, 0, 0, 8'h00, 1,   0, 8'h45, 0, 1, 0, 0, 1);
        tbl[21] = mk(0, 1, 0, 0, 8'h00, 0,   0, 8'h45, 0, 1, 0, 0, 1);
        tbl[22] = mk(1, 1, 0, 1, 8'h99, 0,   0, 8'h00, 0, 1, 0, 0, 1);

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; flush = tbl[i].flush;
            wv = tbl[i].wv; wd = tbl[i].wd; busy = tbl[i].busy;
            step();
            chk_all($sformatf("v%0d", i), tbl[i].send, tbl[i].data, tbl[i].cnt,
                    tbl[i].emp, tbl[i].ful, tbl[i].ov, tbl[i].rdy);
        end
        rst = 1'b0; en = 1'b0; flush = 1'b0; wv = 1'b0; busy = 1'b0;

        // Fill past capacity with the transmitter disabled.
        for (int i = 0; i < 17; i++) begin
            wv = 1'b1;
            wd = 8'(i);
            step();
            chk($sformatf("fill%0d.count", i), count, (i < 16) ? i + 1 : 16);
            chk($sformatf("fill%0d.full", i),  full,  (i >= 15) ? 1 : 0);
            chk($sformatf("fill%0d.ready", i), ready, (i >= 15) ? 0 : 1);
            chk($sformatf("fill%0d.ovf", i),   ovf,   (i == 16) ? 1 : 0);
        end
        wv = 1'b0;
        step();
        chk("ovf_sticky", ovf, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_all("flush_full", 0, 8'h00, 0, 1, 0, 0, 1);

        // Ordered delivery under a slow transmitter.
        push(8'hA1); push(8'hB2); push(8'hC3);
        chk("order.count", count, 3);
        en = 1'b1;
        send_one(8'hA1, 100);
        send_one(8'hB2, 100);
        send_one(8'hC3, 100);
        sends = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tx_send === 1'b1) sends++;
        end
        chk("order.extra_sends", sends, 0);
        chk("order.empty", empty, 1);
        en = 1'b0;

        // Simultaneous push/pop at count 5, then pointer wrap with integrity.
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        chk("pp.count_before", count, 5);
        wv = 1'b1; wd = 8'h65; en = 1'b1;
        step();
        wv = 1'b0; en = 1'b0;
        chk("pp.count_after", count, 5);
        chk("pp.send", tx_send, 1);
        chk("pp.data", tx_data, 8'h60);
        for (int i = 1; i < 6; i++) q.push_back(8'(8'h60 + i));
        busy = 1'b1; step();
        busy = 1'b0; step();
        for (int i = 0; i < 11; i++) begin
            push(8'(8'h66 + i));
            q.push_back(8'(8'h66 + i));
        end
        chk("wrap.full", full, 1);
        chk("wrap.count", count, 16);
        en = 1'b1;
        while (q.size() > 0) send_one(q.pop_front(), 2);
        chk("wrap.empty", empty, 1);
        en = 1'b0;

        // Flush while a byte is in the SEND handshake.
        for (int i = 0; i < 9; i++) push(8'(8'h80 + i));
        en = 1'b1;
        step();
        chk("fs.send", tx_send, 1);
        chk("fs.count", count, 8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_all("fs.flushed", 1, 8'h80, 0, 1, 0, 0, 1);
        busy = 1'b1; step();
        chk("fs.drop", tx_send, 0);
        chk("fs.data_kept", tx_data, 8'h80);
        busy = 1'b0;
        sends = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tx_send === 1'b1) sends++;
        end
        chk("fs.no_more_sends", sends, 0);
        chk("fs.count_end", count, 0);

        // Reset while waiting for the transmitter to finish.
        push(8'h9A);
        step();
        chk("rw.send", tx_send, 1);
        busy = 1'b1; step();
        chk("rw.wait", tx_send, 0);
        rst = 1'b1; step();
        rst = 1'b0;
        chk_all("rw.reset", 0, 8'h00, 0, 1, 0, 0, 1);
        push(8'hAB);
        chk("rw.count", count, 1);
        sends = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (tx_send === 1'b1) sends++;
        end
        chk("rw.held_while_busy", sends, 0);
        busy = 1'b0; step();
        chk("rw.send_after", tx_send, 1);
        chk("rw.data_after", tx_data, 8'hAB);
        busy = 1'b1; step();
        busy = 1'b0; step();
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
